// File: rtl/phy_rx_multilane.sv
// N-lane serial receiver: per-lane comma alignment, lock qualification, byte-to-word
// packing into a small per-lane FIFO, and a round-robin unstriper merging the lanes.
//
// state  | meaning
// SEARCH | sliding the window every clk looking for a comma
// ALIGN  | byte phase fixed, counting consecutive commas at byte boundaries
// LOCKED | aligned; data bytes packed into words, commas treated as idle
module phy_rx_multilane #(
  parameter int         LANES          = 2,
  parameter int         BYTES_PER_WORD = 4,
  parameter logic [7:0] COMMA          = 8'hBC,
  parameter int         SYNC_COUNT     = 4,
  parameter int         FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [LANES-1:0]              in_serial,
  output logic [LANES-1:0]              lock,
  output logic                          all_locked,
  output logic [8*BYTES_PER_WORD-1:0]   data_out,
  output logic                          valid_out,
  output logic [LANES-1:0]              overflow,
  output logic [LANES-1:0]              misalign_err
);
  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int BI_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CC_W   = $clog2(SYNC_COUNT + 1);
  localparam int FA_W   = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} lane_state_t;

  logic [WORD_W-1:0] head [LANES];
  logic [LANES-1:0]  nonempty;
  logic [LANES-1:0]  pop;
  logic [PTR_W-1:0]  ptr;

  assign all_locked = &lock;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_state_t       state;
    logic [7:0]        win;
    logic [7:0]        win_next;
    logic [2:0]        bit_cnt;
    logic [CC_W-1:0]   comma_cnt;
    logic [BI_W-1:0]   byte_idx;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_done;
    logic              push;
    logic [WORD_W-1:0] push_data;
    logic              lock_r;
    logic              misalign_r;
    logic              overflow_r;
    logic [WORD_W-1:0] mem [FIFO_DEPTH];
    logic [FA_W-1:0]   wr_ptr;
    logic [FA_W-1:0]   rd_ptr;
    logic [FA_W:0]     count;
    logic              full;
    logic              wr_en;
    logic              boundary;
    logic              is_comma;

    assign win_next = {win[6:0], in_serial[i]};
    assign boundary = (bit_cnt == 3'd7);
    assign is_comma = (win_next == COMMA);

    // Completed word as it will look once the arriving byte lands in the LSBs.
    always_comb begin
      word_done      = word_buf;
      word_done[7:0] = win_next;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state      <= SEARCH;
        win        <= '0;
        bit_cnt    <= '0;
        comma_cnt  <= '0;
        byte_idx   <= '0;
        word_buf   <= '0;
        push       <= 1'b0;
        push_data  <= '0;
        lock_r     <= 1'b0;
        misalign_r <= 1'b0;
      end else begin
        win     <= win_next;
        bit_cnt <= bit_cnt + 3'd1;
        push    <= 1'b0;
        case (state)
          SEARCH: begin
            if (is_comma) begin
              bit_cnt   <= '0;
              comma_cnt <= CC_W'(1);
              if (SYNC_COUNT == 1) begin
                state  <= LOCKED;
                lock_r <= 1'b1;
              end else begin
                state <= ALIGN;
              end
            end
          end
          ALIGN: begin
            if (boundary) begin
              if (is_comma) begin
                comma_cnt <= comma_cnt + 1'b1;
                if (comma_cnt == CC_W'(SYNC_COUNT - 1)) begin
                  state  <= LOCKED;
                  lock_r <= 1'b1;
                end
              end else begin
                state     <= SEARCH;
                comma_cnt <= '0;
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              if (is_comma) begin
                // A comma inside a word breaks it; the partial word is thrown away.
                if (byte_idx != '0) begin
                  misalign_r <= 1'b1;
                  byte_idx   <= '0;
                end
              end else begin
                for (int b = 0; b < BYTES_PER_WORD; b++) begin
                  if (byte_idx == BI_W'(b)) word_buf[WORD_W-8-8*b +: 8] <= win_next;
                end
                if (byte_idx == BI_W'(BYTES_PER_WORD - 1)) begin
                  push      <= 1'b1;
                  push_data <= word_done;
                  byte_idx  <= '0;
                end else begin
                  byte_idx <= byte_idx + 1'b1;
                end
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end

    assign full        = (count == (FA_W+1)'(FIFO_DEPTH));
    assign nonempty[i] = (count != '0);
    assign head[i]     = mem[rd_ptr];
    assign pop[i]      = all_locked && (ptr == PTR_W'(i)) && nonempty[i];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign wr_en       = push && (!full || pop[i]);

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        overflow_r <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (push && !wr_en) overflow_r <= 1'b1;
        if (pop[i]) rd_ptr <= rd_ptr + 1'b1;
        if (wr_en && !pop[i]) count <= count + 1'b1;
        else if (!wr_en && pop[i]) count <= count - 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign lock[i]         = lock_r;
    assign overflow[i]     = overflow_r;
    assign misalign_err[i] = misalign_r;
  end

  // Strict round robin: the pointer waits on its lane and never skips it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      if (all_locked && nonempty[ptr]) begin
        data_out  <= head[ptr];
        valid_out <= 1'b1;
        ptr       <= (ptr == PTR_W'(LANES - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Bench for phy_rx_multilane: byte-level lane drivers with comma idle fill, a table of
// word vectors, hand sequences for lock/misalign/overflow/reset, and a random phase.
module tb_phy_rx_multilane;
  localparam int         LANES = 2;
  localparam int         BPW   = 4;
  localparam logic [7:0] COMMA = 8'hBC;

  logic              clk = 1'b0;
  logic              reset;
  logic [LANES-1:0]  in_serial;
  logic [LANES-1:0]  lock;
  logic              all_locked;
  logic [8*BPW-1:0]  data_out;
  logic              valid_out;
  logic [LANES-1:0]  overflow;
  logic [LANES-1:0]  misalign_err;

  always #5 clk = ~clk;

  phy_rx_multilane #(
    .LANES(LANES), .BYTES_PER_WORD(BPW), .COMMA(COMMA), .SYNC_COUNT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_serial(in_serial), .lock(lock), .all_locked(all_locked),
    .data_out(data_out), .valid_out(valid_out), .overflow(overflow), .misalign_err(misalign_err)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit  bitq     [LANES][$];
  int  pend     [LANES][$];
  int  wend     [LANES][$];
  bit  cur_data [LANES];
  bit  wmark    [LANES];
  bit  filler_en[LANES];
  logic [31:0] got_q[$];
  int          got_t[$];

  // Reference model: byte-stream packing per lane, then a round-robin merge.
  bit              model_on;
  int              m_idx[LANES];
  logic [31:0]     m_acc[LANES];
  logic [LANES-1:0] m_err;
  logic [31:0]     expq[LANES][$];

  typedef struct {
    logic [31:0] l0a, l0b, l1a, l1b;
    bit          l0two, l1two;
    int          first_lane;
    logic [31:0] e0, e1, e2;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_byte(int l, logic [7:0] b);
    if (b == COMMA) begin
      if (m_idx[l] != 0) begin
        m_err[l] = 1'b1;
        m_idx[l] = 0;
      end
    end else begin
      m_acc[l] = {m_acc[l][23:0], b};
      m_idx[l]++;
      if (m_idx[l] == BPW) begin
        expq[l].push_back(m_acc[l]);
        m_idx[l] = 0;
      end
    end
  endfunction

  task automatic send_byte(int l, logic [7:0] b, bit last);
    int v;
    v = {23'd0, last, b};
    pend[l].push_back(v);
    if (model_on) model_byte(l, b);
  endtask

  task automatic send_word(int l, logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(l, w[8*k +: 8], k == 0);
  endtask

  task automatic push_raw_byte(int l, logic [7:0] b);
    for (int k = 7; k >= 0; k--) bitq[l].push_back(b[k]);
  endtask

  task automatic tick();
    logic [7:0] c;
    int v;
    c = COMMA;
    for (int l = 0; l < LANES; l++) begin
      if (bitq[l].size() == 0) begin
        if (pend[l].size() > 0) begin
          v = pend[l].pop_front();
          for (int k = 7; k >= 0; k--) bitq[l].push_back(v[k]);
          wmark[l]    = v[8];
          cur_data[l] = 1'b1;
        end else if (filler_en[l]) begin
          for (int k = 7; k >= 0; k--) bitq[l].push_back(c[k]);
          wmark[l]    = 1'b0;
          cur_data[l] = 1'b0;
        end
      end
      if (bitq[l].size() > 0) begin
        in_serial[l] = bitq[l].pop_front();
        if (bitq[l].size() == 0) begin
          if (wmark[l]) wend[l].push_back(cyc + 1);
          wmark[l]    = 1'b0;
          cur_data[l] = 1'b0;
        end
      end else begin
        in_serial[l] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (valid_out) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
  endtask

  task automatic drain();
    bit busy;
    busy = 1'b1;
    for (int t = 0; t < 3000 && busy; t++) begin
      busy = 1'b0;
      for (int l = 0; l < LANES; l++) if (pend[l].size() > 0 || cur_data[l]) busy = 1'b1;
      if (busy) tick();
    end
    chk("drain_timeout", busy, 0);
  endtask

  task automatic wait_got(int n, int limit);
    for (int t = 0; t < limit && got_q.size() < n; t++) tick();
  endtask

  task automatic clear_io();
    got_q.delete();
    got_t.delete();
    for (int l = 0; l < LANES; l++) wend[l].delete();
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_lock"}, lock, 0);
    chk({tag, "_all_locked"}, all_locked, 0);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_misalign"}, misalign_err, 0);
  endtask

  function automatic logic [31:0] wk(int k);
    return {8'(16 + k), 8'(32 + k), 8'(48 + k), 8'(64 + k)};
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    do b = 8'($urandom_range(0, 255)); while (b == COMMA);
    return b;
  endfunction

  initial begin
    int r0, r1, ra, e0, nexp, ptr_m;
    logic [31:0] merged[$];

    tbl[0] = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h01020304, 32'h0, 1'b1, 1'b0, 0,
               32'hDEADBEEF, 32'h01020304, 32'hCAFEBABE};
    tbl[1] = '{32'h00000000, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1, 1,
               32'hFFFFFFFF, 32'h00000000, 32'h12345678};
    tbl[2] = '{32'hA5A55A5A, 32'h0F0FF0F0, 32'h80000001, 32'h0, 1'b1, 1'b0, 0,
               32'hA5A55A5A, 32'h80000001, 32'h0F0FF0F0};
    tbl[3] = '{32'h7E7E7E7E, 32'h0, 32'hC3C33C3C, 32'hABCDEF01, 1'b0, 1'b1, 1,
               32'hC3C33C3C, 32'h7E7E7E7E, 32'hABCDEF01};

    model_on = 1'b0;
    m_err    = '0;
    for (int l = 0; l < LANES; l++) begin
      filler_en[l] = 1'b0;
      cur_data[l]  = 1'b0;
      wmark[l]     = 1'b0;
      m_idx[l]     = 0;
      m_acc[l]     = '0;
    end
    in_serial = '0;
    reset     = 1'b1;
    tick();
    tick();
    check_reset_state("init");
    reset = 1'b0;
    repeat (3) tick();

    // Lock timing: lane0 gets a 3-bit offset ahead of its commas.
    bitq[0].push_back(1'b1);
    bitq[0].push_back(1'b0);
    bitq[0].push_back(1'b1);
    for (int n = 0; n < 4; n++) begin
      push_raw_byte(0, COMMA);
      push_raw_byte(1, COMMA);
    end
    filler_en[0] = 1'b1;
    filler_en[1] = 1'b1;
    r0 = -1; r1 = -1; ra = -1;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (lock[0] && r0 < 0) r0 = k;
      if (lock[1] && r1 < 0) r1 = k;
      if (all_locked && ra < 0) ra = k;
    end
    chk("lock1_rise", r1, 32);
    chk("lock0_rise", r0, 35);
    chk("all_locked_rise", ra, 35);

    // Table of word vectors with expected merged order.
    for (int i = 0; i < 4; i++) begin
      clear_io();
      send_word(0, tbl[i].l0a);
      if (tbl[i].l0two) send_word(0, tbl[i].l0b);
      send_word(1, tbl[i].l1a);
      if (tbl[i].l1two) send_word(1, tbl[i].l1b);
      wait_got(3, 400);
      repeat (16) tick();
      chk($sformatf("tbl%0d_count", i), got_q.size(), 3);
      if (got_q.size() >= 3) begin
        chk($sformatf("tbl%0d_w0", i), got_q[0], tbl[i].e0);
        chk($sformatf("tbl%0d_w1", i), got_q[1], tbl[i].e1);
        chk($sformatf("tbl%0d_w2", i), got_q[2], tbl[i].e2);
      end
      if (got_t.size() > 0 && wend[tbl[i].first_lane].size() > 0)
        chk($sformatf("tbl%0d_latency", i), got_t[0], wend[tbl[i].first_lane][0] + 2);
    end

    // Comma inside a word: partial word discarded, next word intact.
    clear_io();
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    send_byte(0, COMMA, 1'b0);
    send_word(0, 32'h11223344);
    send_word(1, 32'h13579ACE);
    wait_got(2, 400);
    repeat (16) tick();
    chk("mis_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("mis_w0", got_q[0], 32'h11223344);
      chk("mis_w1", got_q[1], 32'h13579ACE);
    end
    chk("mis_flag", misalign_err, 2'b01);

    // Overflow: unstriper stalls on lane1 while lane0 floods its FIFO.
    clear_io();
    for (int k = 1; k <= 6; k++) send_word(0, wk(k));
    drain();
    repeat (10) tick();
    chk("ovf_count", got_q.size(), 1);
    if (got_q.size() >= 1) chk("ovf_w1", got_q[0], wk(1));
    chk("ovf_flag", overflow, 2'b01);
    clear_io();
    send_word(1, 32'h5A5A0001);
    wait_got(2, 200);
    repeat (10) tick();
    chk("ovf_resume_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("ovf_resume_l1", got_q[0], 32'h5A5A0001);
      chk("ovf_resume_w2", got_q[1], wk(2));
    end

    // Reset mid-stream clears everything, including sticky flags.
    send_word(0, 32'h77665544);
    repeat (12) tick();
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("midrst");
    for (int l = 0; l < LANES; l++) begin
      bitq[l].delete();
      pend[l].delete();
      cur_data[l]  = 1'b0;
      wmark[l]     = 1'b0;
      filler_en[l] = 1'b0;
    end
    reset = 1'b0;
    tick();
    tick();

    // Comma run broken by a data byte restarts the count.
    filler_en[0] = 1'b1;
    filler_en[1] = 1'b1;
    e0 = cyc + 1;
    send_byte(0, COMMA, 1'b0);
    send_byte(0, COMMA, 1'b0);
    send_byte(0, 8'h55, 1'b0);
    for (int n = 0; n < 4; n++) send_byte(0, COMMA, 1'b0);
    r0 = -1; ra = -1;
    for (int k = 0; k < 90; k++) begin
      tick();
      if (lock[0] && r0 < 0) r0 = cyc;
      if (all_locked && ra < 0) ra = cyc;
    end
    chk("relock0_rise", r0, e0 + 55);
    chk("relock_all_rise", ra, e0 + 55);

    // Random words with idle commas and occasional broken partial words.
    clear_io();
    model_on = 1'b1;
    m_err    = '0;
    for (int l = 0; l < LANES; l++) begin
      m_idx[l] = 0;
      expq[l].delete();
    end
    for (int r = 0; r < 20; r++) begin
      for (int l = 0; l < LANES; l++) begin
        int nc, np;
        nc = $urandom_range(0, 2);
        for (int n = 0; n < nc; n++) send_byte(l, COMMA, 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          np = $urandom_range(1, 3);
          for (int n = 0; n < np; n++) send_byte(l, rand_byte(), 1'b0);
          send_byte(l, COMMA, 1'b0);
        end
        send_word(l, {rand_byte(), rand_byte(), rand_byte(), rand_byte()});
      end
      drain();
    end
    ptr_m = 0;
    merged.delete();
    while (expq[ptr_m].size() > 0) begin
      merged.push_back(expq[ptr_m].pop_front());
      ptr_m = (ptr_m + 1) % LANES;
    end
    nexp = merged.size();
    wait_got(nexp, 500);
    repeat (16) tick();
    chk("rand_count", got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++)
      chk($sformatf("rand_w%0d", i), got_q[i], merged[i]);
    chk("rand_misalign", misalign_err, m_err);
    chk("rand_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
